operand_fetch: RTL and testbench

- Register-read initiator for the ID stage. The register file has one read port; this block drives it.
- Accepts one decoded instruction's source register addresses (rs1, rs2) and issues up to two sequential reads over the register file's single synchronous read port.
- Captures the returned values and keeps them coherent with write-back traffic until the downstream execute stage takes them.
- Forces x0 to read as zero, whatever the register file's initial contents.

---
 rtl/of_pkg.sv | 19 +
 rtl/operand_snoop_reg.sv | 74 +++++++
 rtl/operand_fetch.sv | 150 +++++++++++++++
 tb/tb_operand_fetch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/of_pkg.sv
// Shared definitions for the operand fetch block.
// Contents:
//   ADDR_WIDTH_DEF / DATA_WIDTH_DEF : default register address / data widths
//   X0_ADDR                          : hard-wired zero register address
//   of_state_t                       : fetch sequencer states
package of_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int X0_ADDR        = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } of_state_t;

endpackage

// File: rtl/operand_snoop_reg.sv
// One source-operand register together with the register address it belongs to.
// The value is loaded by capture (x0 -> 0, else a matching write-back, else the
// register file read data), and can be refreshed by a write-back snoop while held.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   load_addr        : latch addr_in as the operand's register address
//   addr_in          : register address of a newly accepted instruction
//   capture          : load the value from the capture priority chain
//   clear            : force the value to zero (operand not used)
//   snoop            : allow a write-back to the held address to update the value
//   rf_dout          : register file read data
//   wb_we/addr/din   : write-back port
//   addr             : latched register address
//   val              : operand value
module operand_snoop_reg
    import of_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  capture,
    input  logic                  clear,
    input  logic                  snoop,
    input  logic [DATA_WIDTH-1:0] rf_dout,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_din,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] val
);

    logic                  is_x0;
    logic                  wb_hit;
    logic [DATA_WIDTH-1:0] capture_val;

    assign is_x0  = (addr == ADDR_WIDTH'(X0_ADDR));
    // A write to x0 never counts as a hit, so x0 stays zero under snooping.
    assign wb_hit = wb_we && (wb_addr == addr) && !is_x0;

    // Write-back data is newer than what the register file read returned.
    always_comb begin
        capture_val = rf_dout;
        if (is_x0) begin
            capture_val = '0;
        end else if (wb_hit) begin
            capture_val = wb_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load_addr) begin
            addr <= addr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (clear) begin
            val <= '0;
        end else if (capture) begin
            val <= capture_val;
        end else if (snoop && wb_hit) begin
            val <= wb_din;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch for the ID stage: sequences up to two reads of rs1/rs2 over the
// register file's single synchronous read port and holds the operands, kept
// fresh against write-back, until the execute stage accepts them.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : decoder handshake
//   req_rs1/req_rs2/req_use_rs2 : source addresses, rs2-needed flag
//   rf_read_addr / rf_dout      : register file read port (1-cycle latency)
//   wb_we/wb_addr/wb_din        : write-back port
//   op_valid/op_ready           : execute stage handshake
//   op_rs1_val/op_rs2_val       : operands
module operand_fetch
    import of_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    input  logic                  req_use_rs2,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_dout,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_din,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_rs1_val,
    output logic [DATA_WIDTH-1:0] op_rs2_val
);

    of_state_t             state, state_next;
    logic                  use_rs2_q;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
    logic                  accept;
    logic                  req_ready_c;
    logic                  cap1, cap2, clr2, snoop1, snoop2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            use_rs2_q <= 1'b0;
            op_valid  <= 1'b0;
        end else begin
            state    <= state_next;
            op_valid <= (state_next == HOLD);
            if (accept) begin
                use_rs2_q <= req_use_rs2;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rf_read_addr = req_rs1;
        req_ready_c  = 1'b0;
        accept       = 1'b0;
        cap1         = 1'b0;
        cap2         = 1'b0;
        clr2         = 1'b0;
        snoop1       = 1'b0;
        snoop2       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = RD1;
                end
            end
            RD1: begin
                // rf_dout carries rs1 now; issue the rs2 read in the same cycle.
                rf_read_addr = rs2_q;
                cap1         = 1'b1;
                if (use_rs2_q && (rs2_q != rs1_q)) begin
                    state_next = RD2;
                end else begin
                    state_next = HOLD;
                    // Same register: the rs1 capture chain yields the rs2 value too.
                    cap2 = use_rs2_q;
                    clr2 = !use_rs2_q;
                end
            end
            RD2: begin
                cap2       = 1'b1;
                snoop1     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                snoop1      = 1'b1;
                snoop2      = use_rs2_q;
                req_ready_c = op_ready;
                if (op_ready) begin
                    if (req_valid) begin
                        accept     = 1'b1;
                        state_next = RD1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = rst_n && req_ready_c;

    operand_snoop_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rs1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_addr(accept),
        .addr_in  (req_rs1),
        .capture  (cap1),
        .clear    (1'b0),
        .snoop    (snoop1),
        .rf_dout  (rf_dout),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_din   (wb_din),
        .addr     (rs1_q),
        .val      (op_rs1_val)
    );

    operand_snoop_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rs2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_addr(accept),
        .addr_in  (req_rs2),
        .capture  (cap2),
        .clear    (clr2),
        .snoop    (snoop2),
        .rf_dout  (rf_dout),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_din   (wb_din),
        .addr     (rs2_q),
        .val      (op_rs2_val)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small synchronous register file model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1, req_rs2;
    logic        req_use_rs2;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_dout;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_din;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_rs1_val, op_rs2_val;

    logic [31:0] rf_mem [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_use_rs2 (req_use_rs2),
        .rf_read_addr(rf_read_addr),
        .rf_dout     (rf_dout),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_din      (wb_din),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_rs1_val  (op_rs1_val),
        .op_rs2_val  (op_rs2_val)
    );

    // Register file: synchronous read, same-cycle write bypass.
    always @(posedge clk) begin
        if (wb_we) rf_mem[wb_addr] <= wb_din;
        rf_dout <= (wb_we && wb_addr == rf_read_addr) ? wb_din : rf_mem[rf_read_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            $display("check %s: observed=%h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a;
        wb_din  = d;
        tick();
        wb_we   = 1'b0;
    endtask

    task automatic request(input logic [4:0] r1, input logic [4:0] r2, input logic use2);
        req_valid   = 1'b1;
        req_rs1     = r1;
        req_rs2     = r2;
        req_use_rs2 = use2;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use_rs2 = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_din = '0; op_ready = 1'b0;
        tick(); tick();
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_op_valid", 32'(op_valid), 32'd0);
        chk("reset_rs1_val", op_rs1_val, 32'd0);
        chk("reset_rs2_val", op_rs2_val, 32'd0);
        rst_n = 1'b1; #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        wb_write(5'd3, 32'h11);
        wb_write(5'd7, 32'h22);
        wb_write(5'd0, 32'hDEADBEEF);
        wb_write(5'd4, 32'h1);
        wb_write(5'd9, 32'h77);

        // Two distinct reads: x3 then x7, operands on cycle 3.
        request(5'd3, 5'd7, 1'b1); #1;
        chk("two_rd_c0_addr", 32'(rf_read_addr), 32'd3);
        chk("two_rd_c0_ready", 32'(req_ready), 32'd1);
        tick(); req_valid = 1'b0; #1;
        chk("two_rd_c1_addr", 32'(rf_read_addr), 32'd7);
        chk("two_rd_c1_valid", 32'(op_valid), 32'd0);
        tick();
        chk("two_rd_c2_valid", 32'(op_valid), 32'd0);
        tick();
        chk("two_rd_c3_valid", 32'(op_valid), 32'd1);
        chk("two_rd_rs1", op_rs1_val, 32'h11);
        chk("two_rd_rs2", op_rs2_val, 32'h22);
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        chk("two_rd_drain_valid", 32'(op_valid), 32'd0);

        // Reset in the middle of RD1 wipes the held operands.
        request(5'd5, 5'd5, 1'b0);
        tick(); req_valid = 1'b0;
        rst_n = 1'b0; #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_op_valid", 32'(op_valid), 32'd0);
        chk("midrst_rs1_val", op_rs1_val, 32'd0);
        chk("midrst_rs2_val", op_rs2_val, 32'd0);
        tick(); rst_n = 1'b1; req_rs1 = 5'd6; #1;
        chk("midrst_idle_ready", 32'(req_ready), 32'd1);
        chk("midrst_idle_addr", 32'(rf_read_addr), 32'd6);

        // x0 on both sources: one read, zeros despite the RF holding DEADBEEF.
        request(5'd0, 5'd0, 1'b1);
        tick(); req_valid = 1'b0; #1;
        chk("x0_c1_valid", 32'(op_valid), 32'd0);
        chk("x0_c1_addr", 32'(rf_read_addr), 32'd0);
        tick();
        chk("x0_c2_valid", 32'(op_valid), 32'd1);
        chk("x0_rs1", op_rs1_val, 32'd0);
        chk("x0_rs2", op_rs2_val, 32'd0);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // Same register on both sources with a write-back during RD1.
        request(5'd4, 5'd4, 1'b1);
        tick(); req_valid = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd4; wb_din = 32'h99;
        tick(); wb_we = 1'b0;
        chk("bypass_valid", 32'(op_valid), 32'd1);
        chk("bypass_rs1", op_rs1_val, 32'h99);
        chk("bypass_rs2", op_rs2_val, 32'h99);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // Stalled operands snoop a write-back to x7.
        request(5'd3, 5'd7, 1'b1);
        tick(); req_valid = 1'b0;
        tick(); tick();
        chk("stall_h1_valid", 32'(op_valid), 32'd1);
        chk("stall_h1_rs2", op_rs2_val, 32'h22);
        tick();
        chk("stall_h2_rs2", op_rs2_val, 32'h22);
        wb_write(5'd7, 32'h55);
        chk("stall_h3_valid", 32'(op_valid), 32'd1);
        chk("stall_h3_rs2", op_rs2_val, 32'h55);
        chk("stall_h3_rs1", op_rs1_val, 32'h11);
        tick();
        chk("stall_h4_valid", 32'(op_valid), 32'd1);

        // Back-to-back: new request accepted directly from HOLD, rs2 unused.
        op_ready = 1'b1;
        request(5'd9, 5'd7, 1'b0); #1;
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
        chk("b2b_addr", 32'(rf_read_addr), 32'd9);
        tick(); op_ready = 1'b0; req_valid = 1'b0; #1;
        chk("b2b_c1_valid", 32'(op_valid), 32'd0);
        chk("b2b_c1_ready", 32'(req_ready), 32'd0);
        tick();
        chk("b2b_c2_valid", 32'(op_valid), 32'd1);
        chk("b2b_rs1", op_rs1_val, 32'h77);
        chk("b2b_rs2", op_rs2_val, 32'd0);
        wb_write(5'd7, 32'h66);
        chk("b2b_rs2_nosnoop", op_rs2_val, 32'd0);
        chk("b2b_hold_valid", 32'(op_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
